// File: rtl/inst_encode_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: opcode set, format codes,
// field bit positions, FSM state type and the field-packing helper.
package inst_encode_loader_pkg;

  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_SUB  = 7'h02;
  localparam logic [6:0] OP_AND  = 7'h03;
  localparam logic [6:0] OP_OR   = 7'h04;
  localparam logic [6:0] OP_XOR  = 7'h05;
  localparam logic [6:0] OP_ADI  = 7'h06;
  localparam logic [6:0] OP_LSL  = 7'h07;
  localparam logic [6:0] OP_LSR  = 7'h08;
  localparam logic [6:0] OP_LD   = 7'h09;
  localparam logic [6:0] OP_ST   = 7'h0A;
  localparam logic [6:0] OP_HALT = 7'h7F;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_S   = 2'b10;
  localparam logic [1:0] FMT_RSV = 2'b11;

  localparam int OPC_LSB = 25;
  localparam int DR_LSB  = 20;
  localparam int SA_LSB  = 15;
  localparam int SB_LSB  = 10;
  localparam int IMM_LSB = 0;
  localparam int SH_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  function automatic logic opcode_known(input logic [6:0] op);
    logic known;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_ADI, OP_LSL, OP_LSR, OP_LD, OP_ST, OP_HALT: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

  // Reserved format packs like reg-reg so the word stays decodable.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  dr,
    input logic [4:0]  sa,
    input logic [4:0]  sb,
    input logic [14:0] imm,
    input logic [4:0]  sh
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    w[OPC_LSB +: 7] = opcode;
    w[DR_LSB  +: 5] = dr;
    w[SA_LSB  +: 5] = sa;
    case (fmt)
      FMT_I:   w[IMM_LSB +: 15] = imm;
      FMT_S:   w[SH_LSB  +: 5]  = sh;
      default: w[SB_LSB  +: 5]  = sb;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_encode_loader_fifo.sv
// inst_fifo: synchronous FIFO buffering encoded instruction words between the
// tuple handshake and the memory write stage.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  // A pop in the same cycle frees the slot, so a push on full is still safe.
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Word storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/inst_encode_loader.sv
// Instruction encoder/loader: packs field tuples into 32-bit words and writes them to
// instruction memory. Optional macro LOADER_OPCHECK_EN drops unknown opcodes / fmt 11.
module inst_encode_loader
  import inst_encode_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        dr,
  input  logic [4:0]        sa,
  input  logic [4:0]        sb,
  input  logic [14:0]       imm,
  input  logic [4:0]        sh,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_busy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  localparam int CW  = ADDR_W + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  loader_state_e     state_r;
  loader_state_e     state_s;
  logic [CW-1:0]     accept_cnt_r;
  logic [CW-1:0]     word_count_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              mem_we_r;
  logic              err_r;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FCW-1:0]    fifo_count_s;
  logic [31:0]       fifo_head_s;
  logic [31:0]       enc_s;
  logic              tuple_ok_s;
  logic              hs_s;
  logic              push_s;
  logic              pop_s;
  logic              complete_s;
  logic              is_halt_s;
  logic              at_limit_s;
  logic              start_s;

  assign enc_s = encode_word(fmt, opcode, dr, sa, sb, imm, sh);

`ifdef LOADER_OPCHECK_EN
  assign tuple_ok_s = opcode_known(opcode) && (fmt != FMT_RSV);
`else
  assign tuple_ok_s = 1'b1;
`endif

  assign in_ready   = (state_r == ST_LOAD) && !fifo_full_s;
  assign hs_s       = in_valid && in_ready;
  assign push_s     = hs_s && tuple_ok_s;
  assign is_halt_s  = (opcode == OP_HALT);
  assign at_limit_s = (accept_cnt_r == CW'(MAX_WORDS - 1));
  assign start_s    = (state_r == ST_IDLE) && start;
  assign complete_s = mem_we_r && !mem_busy;
  // Refill the write register whenever it is empty or its word retires this cycle.
  assign pop_s      = !fifo_empty_s && (!mem_we_r || !mem_busy);

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (enc_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Load sequencing next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (push_s && (is_halt_s || at_limit_s)) state_s = ST_DRAIN;
        else                                     state_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if ((fifo_count_s == FCW'(0)) && !mem_we_r) state_s = ST_DONE;
        else                                        state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Per-load bookkeeping: accept count, error flag, write address and written count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt_r <= CW'(0);
      word_count_r <= CW'(0);
      mem_addr_r   <= ADDR_W'(0);
      err_r        <= 1'b0;
    end else if (start_s) begin
      accept_cnt_r <= CW'(0);
      word_count_r <= CW'(0);
      mem_addr_r   <= base_addr;
      err_r        <= 1'b0;
    end else begin
      if (push_s) accept_cnt_r <= accept_cnt_r + CW'(1);
      // HALT landing exactly on the limit is a clean finish, not an overflow.
      if (hs_s && !tuple_ok_s)                    err_r <= 1'b1;
      else if (push_s && at_limit_s && !is_halt_s) err_r <= 1'b1;
      if (complete_s) begin
        mem_addr_r   <= mem_addr_r + ADDR_W'(1);
        word_count_r <= word_count_r + CW'(1);
      end
    end
  end

  // Memory write register; held while the memory stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'h0000_0000;
    end else if (pop_s) begin
      mem_we_r    <= 1'b1;
      mem_wdata_r <= fifo_head_s;
    end else if (complete_s) begin
      mem_we_r    <= 1'b0;
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign err        = err_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Self-checking bench for inst_encode_loader: directed and randomized loads compared
// against a queue-based reference model of the encoded word stream.
`timescale 1ns/1ps
module tb_inst_encode_loader;
  import inst_encode_loader_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start4 = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    fmt = '0;
  logic [6:0]    opcode = '0;
  logic [4:0]    dr = '0, sa = '0, sb = '0, sh = '0;
  logic [14:0]   imm = '0;
  logic          mem_busy = 1'b0;

  logic          in_ready, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic          in_ready4, mem_we4, busy4, done4, err4;
  logic [AW-1:0] mem_addr4;
  logic [31:0]   mem_wdata4;
  logic [AW:0]   word_count4;

  inst_encode_loader #(.ADDR_W(AW), .FIFO_DEPTH(4), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .dr(dr), .sa(sa), .sb(sb), .imm(imm), .sh(sh),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  inst_encode_loader #(.ADDR_W(AW), .FIFO_DEPTH(4), .MAX_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready4), .fmt(fmt), .opcode(opcode),
    .dr(dr), .sa(sa), .sb(sb), .imm(imm), .sh(sh),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_busy(mem_busy),
    .busy(busy4), .done(done4), .err(err4), .word_count(word_count4)
  );

  always #5 clk = ~clk;

  logic          sel4 = 1'b0;
  logic          m_ready, m_we, m_done, m_err, m_busy;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [AW:0]   m_wc;
  assign m_ready = sel4 ? in_ready4   : in_ready;
  assign m_we    = sel4 ? mem_we4     : mem_we;
  assign m_done  = sel4 ? done4       : done;
  assign m_err   = sel4 ? err4        : err;
  assign m_busy  = sel4 ? busy4       : busy;
  assign m_addr  = sel4 ? mem_addr4   : mem_addr;
  assign m_wdata = sel4 ? mem_wdata4  : mem_wdata;
  assign m_wc    = sel4 ? word_count4 : word_count;

  // Memory stall driver: random or forced.
  logic rand_busy = 1'b0;
  logic busy_force = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    mem_busy = rand_busy ? 1'($urandom_range(0, 1)) : busy_force;
  end

  // Records every completed memory write and every done pulse.
  logic [39:0] got_q[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (!rst && m_we && !mem_busy) got_q.push_back({m_addr, m_wdata});
    if (!rst && m_done) done_cnt++;
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          q0 = 0;
  int          d0 = 0;
  logic [6:0]  ops [11];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packing computed with plain arithmetic on field weights.
  function automatic logic [31:0] ref_encode(input int f, input int op, input int d,
                                             input int a, input int b, input int im, input int s);
    longint w;
    w = longint'(op) * 33554432 + longint'(d) * 1048576 + longint'(a) * 32768;
    if (f == 1)      w = w + longint'(im);
    else if (f == 2) w = w + longint'(s);
    else             w = w + longint'(b) * 1024;
    return w[31:0];
  endfunction

  function automatic bit ref_dropped(input int f);
`ifdef LOADER_OPCHECK_EN
    return (f == 3);
`else
    return (f < 0);
`endif
  endfunction

  task automatic try_send(input int f, input int op, input int d, input int a, input int b,
                          input int im, input int s, input int budget, output bit ok);
    fmt = f[1:0]; opcode = op[6:0]; dr = d[4:0]; sa = a[4:0];
    sb = b[4:0]; imm = im[14:0]; sh = s[4:0];
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (ok && !ref_dropped(f)) exp_q.push_back(ref_encode(f, op, d, a, b, im, s));
  endtask

  task automatic send(input int f, input int op, input int d, input int a, input int b,
                      input int im, input int s);
    bit ok;
    try_send(f, op, d, a, b, im, s, 300, ok);
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic send_rand();
    send($urandom_range(0, 2), int'(ops[$urandom_range(0, 10)]), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 32767),
         $urandom_range(0, 31));
  endtask

  task automatic begin_load(input logic [AW-1:0] b, input logic use4);
    base_addr = b;
    sel4 = use4;
    exp_q.delete();
    q0 = got_q.size();
    d0 = done_cnt;
    if (use4) start4 = 1'b1;
    else      start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic finish_load(input string tag, input logic [AW-1:0] b, input logic exp_err);
    bit seen;
    int n;
    logic [AW-1:0] ea;
    logic [39:0] wv;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (m_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    @(negedge clk);
    n = got_q.size() - q0;
    check({tag, "_nwrites"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      wv = got_q[q0 + i];
      ea = b + AW'(i);
      check({tag, "_addr"}, 64'(wv[39:32]), 64'(ea));
      check({tag, "_data"}, 64'(wv[31:0]), 64'(exp_q[i]));
    end
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_word_count"}, 64'(m_wc), 64'(exp_q.size()));
    check({tag, "_err"}, 64'(m_err), 64'(exp_err));
    check({tag, "_idle"}, 64'(m_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int n_acc;
    logic [39:0] wv;
    logic [AW+32:0] hold;
    ops = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADI, OP_LSL, OP_LSR, OP_LD, OP_ST};

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_mem_we",     64'(mem_we),     64'd0);
    check("rst_mem_addr",   64'(mem_addr),   64'd0);
    check("rst_mem_wdata",  64'(mem_wdata),  64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_err",        64'(err),        64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic ADD + HALT at 0x10.
    begin_load(8'h10, 1'b0);
    send(0, int'(OP_ADD), 1, 2, 3, 0, 0);
    send(0, int'(OP_HALT), 0, 0, 0, 0, 0);
    finish_load("basic", 8'h10, 1'b0);
    if (got_q.size() > q0) begin
      wv = got_q[q0];
      check("basic_first_word", 64'(wv[31:0]), 64'({OP_ADD, 5'd1, 5'd2, 5'd3, 10'd0}));
    end else begin
      check("basic_first_present", 64'(got_q.size()), 64'(q0 + 1));
    end

    // Immediate and shift extremes plus random tuples under random stalls.
    rand_busy = 1'b1;
    begin_load(8'h40, 1'b0);
    send(1, int'(OP_ADI), 7, 8, 0, 32'h7FFF, 0);
    send(2, int'(OP_LSL), 9, 10, 0, 0, 31);
    for (int i = 0; i < 14; i++) send_rand();
    send(0, int'(OP_HALT), 0, 0, 0, 0, 0);
    finish_load("rand", 8'h40, 1'b0);
    if (got_q.size() > q0 + 1) begin
      wv = got_q[q0];
      check("adi_imm", 64'(wv[14:0]), 64'h7FFF);
      wv = got_q[q0 + 1];
      check("lsl_mid_zero", 64'(wv[14:5]), 64'd0);
      check("lsl_sh", 64'(wv[4:0]), 64'd31);
    end else begin
      check("rand_words_present", 64'(got_q.size() - q0), 64'd2);
    end
    rand_busy = 1'b0;

    // Sustained stall from 0xFE: fill until refused, hold, release, address wraps.
    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    begin_load(8'hFE, 1'b0);
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      try_send($urandom_range(0, 2), int'(ops[$urandom_range(0, 10)]), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 32767),
               $urandom_range(0, 31), 4, ok);
      if (!ok) break;
      n_acc++;
    end
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_no_write", 64'(got_q.size()), 64'(q0));
    hold = {mem_we, mem_addr, mem_wdata};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({mem_we, mem_addr, mem_wdata}), 64'(hold));
    end
    busy_force = 1'b0;
    send(0, int'(OP_HALT), 0, 0, 0, 0, 0);
    finish_load("stall", 8'hFE, 1'b0);

    // Overflow on the MAX_WORDS=4 instance.
    begin_load(8'h20, 1'b1);
    for (int i = 0; i < 4; i++) send_rand();
    @(negedge clk);
    check("maxw_in_ready", 64'(in_ready4), 64'd0);
    finish_load("maxw", 8'h20, 1'b1);

    // Reset mid-load with words buffered behind a stalled memory.
    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    begin_load(8'h30, 1'b0);
    for (int i = 0; i < 3; i++) send_rand();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_we", 64'(mem_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_word_count", 64'(word_count), 64'd0);
    check("midrst_no_write", 64'(got_q.size()), 64'(q0));
    @(posedge clk);
    #1 rst = 1'b0;
    busy_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    begin_load(8'h50, 1'b0);
    send(0, int'(OP_SUB), 4, 5, 6, 0, 0);
    send(0, int'(OP_HALT), 0, 0, 0, 0, 0);
    finish_load("reload", 8'h50, 1'b0);

    // Reserved format tuple.
    begin_load(8'h60, 1'b0);
    send(3, int'(OP_ADD), 11, 12, 13, 32'h1234, 7);
    send(0, int'(OP_HALT), 0, 0, 0, 0, 0);
`ifdef LOADER_OPCHECK_EN
    finish_load("fmt11", 8'h60, 1'b1);
`else
    finish_load("fmt11", 8'h60, 1'b0);
    if (got_q.size() > q0) begin
      wv = got_q[q0];
      check("fmt11_as_rr", 64'(wv[31:0]), 64'({OP_ADD, 5'd11, 5'd12, 5'd13, 10'd0}));
    end else begin
      check("fmt11_present", 64'(got_q.size()), 64'(q0 + 1));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
